// File: rtl/izh_neuron_scheduler.sv
// rtl/izh_neuron_scheduler.sv - time-multiplexed Izhikevich neuron scheduler with spike event FIFO
module izh_neuron_scheduler #(
    parameter int N_NEURONS  = 8,
    parameter int ID_W       = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            tick_start,
    output logic            busy,
    output logic            done,
    input  logic            cur_we,
    input  logic [ID_W-1:0] cur_addr,
    input  logic [7:0]      cur_data,
    output logic [15:0]     dp_v,
    output logic [15:0]     dp_u,
    output logic [7:0]      dp_i,
    input  logic [15:0]     dp_v_next,
    input  logic [15:0]     dp_u_next,
    input  logic            dp_spike,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_id,
    output logic            evt_overflow,
    input  logic            ovf_clear
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EVAL, S_DONE} state_t;

    state_t          state;
    state_t          state_nx;
    logic [ID_W-1:0] idx;
    logic            last_idx;

    logic [15:0]     v_mem   [N_NEURONS];
    logic [15:0]     u_mem   [N_NEURONS];
    logic [7:0]      cur_mem [N_NEURONS];

    logic [ID_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            full;
    logic            push_req;
    logic            pop;
    logic            do_push;
    logic            drop;

    assign last_idx  = (idx == ID_W'(N_NEURONS - 1));
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    assign evt_valid = (count != '0);
    assign evt_id    = fifo_mem[rd_ptr];
    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign push_req  = (state == S_EVAL) && dp_spike;
    assign pop       = evt_valid && evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    // State register; reset aborts any timestep in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // Next-state logic: one FETCH/EVAL pair per neuron, then a single DONE cycle.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (tick_start) state_nx = S_FETCH;
            S_FETCH: state_nx = S_EVAL;
            S_EVAL:  state_nx = last_idx ? S_DONE : S_FETCH;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Neuron index: cleared at timestep start, advanced after each EVAL.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          idx <= '0;
        else if (state == S_IDLE && tick_start) idx <= '0;
        else if (state == S_EVAL && !last_idx)  idx <= idx + ID_W'(1);
    end

    // Datapath operand registers; they only change in FETCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_v <= '0;
            dp_u <= '0;
            dp_i <= '0;
        end else if (state == S_FETCH) begin
            dp_v <= v_mem[idx];
            dp_u <= u_mem[idx];
            dp_i <= cur_mem[idx];
        end
    end

    // State writeback of the datapath result for the neuron under evaluation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                v_mem[n] <= '0;
                u_mem[n] <= '0;
            end
        end else if (state == S_EVAL) begin
            v_mem[idx] <= dp_v_next;
            u_mem[idx] <= dp_u_next;
        end
    end

    // Input current file, writable at any time; a same-cycle FETCH sees the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < N_NEURONS; n++) cur_mem[n] <= '0;
        end else if (cur_we && (int'(cur_addr) < N_NEURONS)) begin
            cur_mem[cur_addr] <= cur_data;
        end
    end

    // Spike event FIFO; never stalls the timestep, drops on overflow instead.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int e = 0; e < FIFO_DEPTH; e++) fifo_mem[e] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                fifo_mem[wr_ptr] <= idx;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !pop)      count <= count + (PW+1)'(1);
            else if (!do_push && pop) count <= count - (PW+1)'(1);
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       evt_overflow <= 1'b0;
        else if (drop)      evt_overflow <= 1'b1;
        else if (ovf_clear) evt_overflow <= 1'b0;
    end

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// tb/tb_izh_neuron_scheduler.sv - self-checking bench for izh_neuron_scheduler
module tb_izh_neuron_scheduler;

    localparam int N  = 8;
    localparam int FD = 4;

    logic        clk;
    logic        reset_n;
    logic        tick_start;
    logic        busy;
    logic        done;
    logic        cur_we;
    logic [2:0]  cur_addr;
    logic [7:0]  cur_data;
    logic [15:0] dp_v;
    logic [15:0] dp_u;
    logic [7:0]  dp_i;
    logic [15:0] dp_v_next;
    logic [15:0] dp_u_next;
    logic        dp_spike;
    logic        evt_valid;
    logic        evt_ready;
    logic [2:0]  evt_id;
    logic        evt_overflow;
    logic        ovf_clear;

    logic [15:0] v_inc;
    logic [15:0] u_inc;
    logic [7:0]  mask;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mv [N];
    logic [15:0] mu [N];
    logic [7:0]  mc [N];
    int          q [$];
    logic        m_ovf;
    logic [15:0] edp_v;
    logic [15:0] edp_u;
    logic [7:0]  edp_i;
    int          t;          // 0 idle; 1..17 = cycles since tick_start was sampled
    int          ready_mode; // 0 never, 1 always, 2 random
    int          we_pct;
    int          clr_pct;

    izh_neuron_scheduler #(.N_NEURONS(N), .ID_W(3), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset_n(reset_n), .tick_start(tick_start), .busy(busy), .done(done),
        .cur_we(cur_we), .cur_addr(cur_addr), .cur_data(cur_data),
        .dp_v(dp_v), .dp_u(dp_u), .dp_i(dp_i),
        .dp_v_next(dp_v_next), .dp_u_next(dp_u_next), .dp_spike(dp_spike),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
        .evt_overflow(evt_overflow), .ovf_clear(ovf_clear)
    );

    // Stub datapath: fixed increments, spike driven by the bench
    assign dp_v_next = dp_v + v_inc;
    assign dp_u_next = dp_u + u_inc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            mv[n] = '0; mu[n] = '0; mc[n] = '0;
        end
        q.delete();
        m_ovf = 1'b0;
        edp_v = '0; edp_u = '0; edp_i = '0;
        t = 0;
    endtask

    // Called at a falling edge: checks outputs, drives inputs, advances the model one clock.
    task automatic clk_cycle(input logic tk, input logic rdy, input logic clr,
                             input logic we, input logic [2:0] a, input logic [7:0] d);
        bit is_eval, is_fetch, pop_m, push_m;
        int k;
        chk("busy", 32'(busy), 32'(t != 0));
        chk("done", 32'(done), 32'(t == 17));
        chk("evt_valid", 32'(evt_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("evt_id", 32'(evt_id), q[0]);
        chk("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
        chk("dp_v", 32'(dp_v), 32'(edp_v));
        chk("dp_u", 32'(dp_u), 32'(edp_u));
        chk("dp_i", 32'(dp_i), 32'(edp_i));

        is_eval  = (t >= 2) && (t <= 2*N) && (t % 2 == 0);
        is_fetch = (t >= 1) && (t < 2*N) && (t % 2 == 1);
        k = is_eval ? (t/2 - 1) : (t - 1) / 2;

        tick_start = tk;
        evt_ready  = rdy;
        ovf_clear  = clr;
        cur_we     = we;
        cur_addr   = a;
        cur_data   = d;
        dp_spike   = is_eval ? mask[k] : 1'($urandom);

        pop_m  = (q.size() != 0) && rdy;
        push_m = is_eval && mask[k];
        if (push_m && q.size() == FD && !pop_m) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (pop_m) void'(q.pop_front());
        if (push_m && (q.size() < FD)) q.push_back(k);
        if (is_fetch) begin
            edp_v = mv[k]; edp_u = mu[k]; edp_i = mc[k];
        end
        if (is_eval) begin
            mv[k] = edp_v + v_inc;
            mu[k] = edp_u + u_inc;
        end
        if (we) mc[a] = d;
        if (t == 0) t = tk ? 1 : 0;
        else if (t == 2*N + 1) t = 0;
        else t = t + 1;

        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic pick_rdy();
        return (ready_mode == 2) ? 1'($urandom) : (ready_mode == 1);
    endfunction

    task automatic rand_cycle(input logic tk);
        logic we, clr;
        we  = (($urandom % 100) < we_pct);
        clr = (($urandom % 100) < clr_pct);
        clk_cycle(tk, pick_rdy(), clr, we, 3'($urandom), 8'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rand_cycle(1'b0);
    endtask

    task automatic run_step(input int retick_at, input int reset_at);
        int done_at;
        int guard;
        done_at = -1;
        guard = 0;
        rand_cycle(1'b1);
        while (t != 0 && guard < 40) begin
            if (t == reset_at) begin
                reset_n = 1'b0; tick_start = 1'b0; cur_we = 1'b0;
                ovf_clear = 1'b0; evt_ready = 1'b0;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_evt_valid", 32'(evt_valid), 32'd0);
                chk("rst_dp_v", 32'(dp_v), 32'd0);
                chk("rst_overflow", 32'(evt_overflow), 32'd0);
                model_reset();
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            if (done === 1'b1) done_at = t;
            rand_cycle(1'(t == retick_at));
            guard++;
        end
        chk("step_timeout", 32'(t), 32'd0);
        chk("done_latency", 32'(done_at), 32'd17);
    endtask

    initial begin
        reset_n = 1'b0; tick_start = 1'b0; cur_we = 1'b0; cur_addr = '0; cur_data = '0;
        dp_spike = 1'b0; evt_ready = 1'b0; ovf_clear = 1'b0;
        v_inc = 16'h0080; u_inc = 16'h0001; mask = 8'h00;
        ready_mode = 0; we_pct = 0; clr_pct = 0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("reset_evt_id", 32'(evt_id), 32'd0);

        // Idle after reset
        idle(5);

        // Plain timestep with cur[2]=10, then a second one
        clk_cycle(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 8'd10);
        run_step(-1, -1);
        idle(2);
        run_step(-1, -1);
        chk("second_v5", 32'(mv[5]), 32'h0100);
        idle(2);

        // Spikes at 1, 3, 6 drained immediately
        mask = 8'b0100_1010; ready_mode = 1;
        run_step(-1, -1);
        idle(3);

        // Every neuron spikes with no consumer: overflow, then drain in order and clear
        mask = 8'hFF; ready_mode = 0;
        run_step(-1, -1);
        idle(2);
        chk("ovf_set", 32'(evt_overflow), 32'd1);
        ready_mode = 1;
        idle(6);
        ready_mode = 0;
        clk_cycle(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0);
        idle(2);

        // tick_start again mid-timestep is ignored
        mask = 8'h00; ready_mode = 1;
        run_step(5, -1);
        idle(4);

        // Reset in the middle of a timestep, then state starts from zero
        mask = 8'h24;
        run_step(-1, 7);
        idle(1);
        run_step(-1, -1);
        idle(2);

        // Randomized timesteps with concurrent current writes, pops and clears
        ready_mode = 2; we_pct = 30; clr_pct = 10;
        for (int r = 0; r < 20; r++) begin
            v_inc = 16'($urandom);
            u_inc = 16'($urandom);
            mask  = 8'($urandom);
            run_step((r % 4 == 0) ? int'($urandom_range(2, 16)) : -1, -1);
            idle(int'($urandom_range(0, 3)));
        end
        ready_mode = 1; we_pct = 0; clr_pct = 0;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
